serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/ripple_borrow_digit.sv | 26 ++
 rtl/serial_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared defaults and state encoding for the digit-serial arithmetic blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_arith_pkg;

  // Default operand width and digit width; N must be a multiple of W.
  localparam int N_DEF = 32;
  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_borrow_digit.sv
// One W-bit digit of a ripple-borrow subtractor: d = a - b - bi.
// Latency: purely combinational.
// Backpressure: none.
module ripple_borrow_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         bi_i,
  output logic [W-1:0] d_o,
  output logic         bo_o
);

  // Bit-by-bit borrow chain from the digit LSB upwards.
  always_comb begin
    logic br;
    br  = bi_i;
    d_o = '0;
    for (int i = 0; i < W; i++) begin
      d_o[i] = a_i[i] ^ b_i[i] ^ br;
      br     = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br);
    end
    bo_o = br;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: so = ia - ib - bi, one W-bit digit per cycle, LSB first.
// Latency: result valid N/W cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; no new operands until then.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] ia,
  input  logic [N-1:0] ib,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] so,
  output logic         bo,
  output logic         ov
);

  localparam int ND = N / W;
  // A single-digit configuration still needs a 1-bit counter to be legal.
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  acc_q;
  logic          br_q;
  logic          a_msb_q;
  logic          b_msb_q;
  logic [N-1:0]  so_q;
  logic          bo_q;
  logic          ov_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [W-1:0]  dig_d;
  logic          br_d;
  logic [N-1:0]  acc_d;
  logic          last_digit;
  logic          ov_d;

  // The operand registers shift right each cycle, so the current digit is always the low W bits.
  ripple_borrow_digit #(.W(W)) u_digit (
    .a_i  (a_q[W-1:0]),
    .b_i  (b_q[W-1:0]),
    .bi_i (br_q),
    .d_o  (dig_d),
    .bo_o (br_d)
  );

  // New digit enters at the top of the accumulator; after N/W digits it holds the full difference.
  assign acc_d      = (acc_q >> W) | (N'(dig_d) << (N - W));
  assign last_digit = (cnt_q == CW'(ND - 1));
  // Overflow only from the saved sign bits and the top bit of the final digit.
  assign ov_d       = (a_msb_q != b_msb_q) && (dig_d[W-1] != a_msb_q);

  // Control FSM plus datapath registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      br_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      so_q        <= '0;
      bo_q        <= 1'b0;
      ov_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= ia;
            b_q        <= ib;
            br_q       <= bi;
            a_msb_q    <= ia[N-1];
            b_msb_q    <= ib[N-1];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> W;
          b_q   <= b_q >> W;
          br_q  <= br_d;
          acc_q <= acc_d;
          if (last_digit) begin
            so_q        <= acc_d;
            bo_q        <= br_d;
            ov_q        <= ov_d;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign so        = so_q;
  assign bo        = bo_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, handshake corner cases, random vs model.
// Latency: checks result appears exactly 8 cycles after accept.
// Backpressure: exercises held out_ready and ignored in_valid pulses in DONE.
module tb_serial_subtractor;

  localparam int N = 32;
  localparam int W = 4;
  localparam int LAT = N / W;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] ia;
  logic [N-1:0] ib;
  logic         bi;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] so;
  logic         bo;
  logic         ov;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ia        (ia),
    .ib        (ib),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .so        (so),
    .bo        (bo),
    .ov        (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    logic [N-1:0] s;
    logic         bo;
    logic         ov;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide integer arithmetic on the operand values.
  task automatic ref_sub(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         output logic [N-1:0] s, output logic bor, output logic ovf);
    longint ua, ub, sa, sb, ud, sd;
    ua  = longint'(a);
    ub  = longint'(b);
    ud  = ua - ub - longint'(c);
    s   = ud[N-1:0];
    bor = (ud < 0);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sd  = sa - sb - longint'(c);
    ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
  endtask

  // Apply one operand set; returns the result and the accept-to-valid latency.
  // In DONE, out_ready is withheld for 'hold' cycles while checking output stability.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input int hold, output logic [N-1:0] s_r, output logic bo_r,
                        output logic ov_r, output int lat);
    int t;
    t = 0;
    s_r  = '0;
    bo_r = 1'b0;
    ov_r = 1'b0;
    lat  = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    ia = a; ib = b; bi = c; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ia = $urandom; ib = $urandom; bi = 1'($urandom);
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 50);
    if (!out_valid) begin
      check("out_valid_timeout", 64'(out_valid), 64'd1);
      return;
    end
    s_r = so; bo_r = bo; ov_r = ov;
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      ia = $urandom; ib = $urandom; bi = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_so", 64'(so), 64'(s_r));
      check("hold_bo_ov", {62'd0, bo, ov}, {62'd0, bo_r, ov_r});
      check("hold_valid_ready", {62'd0, out_valid, in_ready}, 64'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("after_hs_valid_ready", {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  vec_t         tbl[8];
  logic [N-1:0] s_got, s_exp;
  logic         bo_got, ov_got, bo_exp, ov_exp;
  int           lat;

  initial begin
    tbl[0] = '{32'd5,          32'd3,          1'b0, 32'd2,          1'b0, 1'b0};
    tbl[1] = '{32'd0,          32'd1,          1'b0, 32'hFFFFFFFF,   1'b1, 1'b0};
    tbl[2] = '{32'h80000000,   32'd1,          1'b0, 32'h7FFFFFFF,   1'b0, 1'b1};
    tbl[3] = '{32'd7,          32'd7,          1'b1, 32'hFFFFFFFF,   1'b1, 1'b0};
    tbl[4] = '{32'd0,          32'd0,          1'b1, 32'hFFFFFFFF,   1'b1, 1'b0};
    tbl[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd0,          1'b0, 1'b0};
    tbl[6] = '{32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h80000000,   1'b1, 1'b1};
    tbl[7] = '{32'h12345678,   32'h11111111,   1'b0, 32'h01234567,   1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ia = '0; ib = '0; bi = 1'b0;
    #12;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_so_bo_ov", {bo, ov, so}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, 0, s_got, bo_got, ov_got, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_so", i), 64'(s_got), 64'(tbl[i].s));
      check($sformatf("vec%0d_bo", i), 64'(bo_got), 64'(tbl[i].bo));
      check($sformatf("vec%0d_ov", i), 64'(ov_got), 64'(tbl[i].ov));
    end

    // Result held under 5 cycles of backpressure with in_valid pulses.
    run_op(32'hDEAD0000, 32'h00BEEF00, 1'b1, 5, s_got, bo_got, ov_got, lat);
    ref_sub(32'hDEAD0000, 32'h00BEEF00, 1'b1, s_exp, bo_exp, ov_exp);
    check("bp_so", 64'(s_got), 64'(s_exp));
    check("bp_bo_ov", {62'd0, bo_got, ov_got}, {62'd0, bo_exp, ov_exp});

    // Reset during the third RUN cycle wipes the outputs at once.
    @(negedge clk);
    ia = 32'h00001234; ib = 32'h1; bi = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_run_out_valid", 64'(out_valid), 64'd0);
    check("rst_run_so", 64'(so), 64'd0);
    check("rst_run_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd100, 32'd58, 1'b1, 0, s_got, bo_got, ov_got, lat);
    check("post_rst_lat", 64'(lat), 64'(LAT));
    check("post_rst_so", 64'(s_got), 64'd41);
    check("post_rst_bo_ov", {62'd0, bo_got, ov_got}, 64'd0);

    // Random operands within 0..999999 with random backpressure.
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] ra, rb;
      logic         rc;
      ra = N'($urandom_range(0, 999999));
      rb = N'($urandom_range(0, 999999));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, $urandom_range(0, 3), s_got, bo_got, ov_got, lat);
      ref_sub(ra, rb, rc, s_exp, bo_exp, ov_exp);
      check("rnd_so", 64'(s_got), 64'(s_exp));
      check("rnd_bo_ov", {62'd0, bo_got, ov_got}, {62'd0, bo_exp, ov_exp});
    end

    // Full-range random operands to reach signed overflow cases.
    for (int i = 0; i < 200; i++) begin
      logic [N-1:0] ra, rb;
      logic         rc;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, $urandom_range(0, 2), s_got, bo_got, ov_got, lat);
      ref_sub(ra, rb, rc, s_exp, bo_exp, ov_exp);
      check("full_so", 64'(s_got), 64'(s_exp));
      check("full_bo_ov", {62'd0, bo_got, ov_got}, {62'd0, bo_exp, ov_exp});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
